// File: rtl/zap_cache_line_fill_pkg.sv
// rtl/zap_cache_line_fill_pkg.sv - shared constants for the cache line fill engine
//
// Wishbone cycle-type identifiers and the cache tag layout used by the
// refill path and the tag RAM it writes into.

package zap_cache_line_fill_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_BURST   = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Cache tag: the tag is the line-aligned physical address PA[31:4]
    localparam int CACHE_TAG_WDT     = 28;
    localparam int CACHE_TAG_PA_MSB  = 27;
    localparam int CACHE_TAG_PA_LSB  = 0;

    // Line geometry
    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 32 * LINE_WORDS;

endpackage

// File: rtl/zap_cache_line_fill.sv
// rtl/zap_cache_line_fill.sv - cache line refill engine (4-beat Wishbone burst, one-cycle line write)
//
// On a fill request the block latches the line-aligned address and tag,
// reads the four words of the line with an incrementing Wishbone burst,
// then writes the whole line and its tag into the tag/data RAM in a single
// cycle.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_fill_req              level request, sampled only in IDLE
//   i_fill_pa, i_fill_tag   fill address (bits [3:0] ignored) and tag
//   o_fill_busy/o_fill_done engine busy, one-cycle completion pulse
//   o_cache_line/_ben       assembled line and byte enables for the RAM write
//   o_cache_tag_wr_en       tag write strobe
//   o_cache_tag/_dirty      latched tag, dirty bit (always clean)
//   o_wb_*                  registered Wishbone master outputs
//   i_wb_ack, i_wb_dat      Wishbone beat acknowledge and read data

module zap_cache_line_fill
    import zap_cache_line_fill_pkg::*;
#(
    parameter int CACHE_SIZE = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_fill_req,
    input  logic [31:0]              i_fill_pa,
    input  logic [CACHE_TAG_WDT-1:0] i_fill_tag,
    output logic                     o_fill_busy,
    output logic                     o_fill_done,
    output logic [LINE_BITS-1:0]     o_cache_line,
    output logic [15:0]              o_cache_line_ben,
    output logic                     o_cache_tag_wr_en,
    output logic [CACHE_TAG_WDT-1:0] o_cache_tag,
    output logic                     o_cache_tag_dirty,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic [31:0]              o_wb_adr,
    output logic                     o_wb_wen,
    output logic [3:0]               o_wb_sel,
    output logic [2:0]               o_wb_cti,
    input  logic                     i_wb_ack,
    input  logic [31:0]              i_wb_dat
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FILL_READ  = 2'd1,
        S_FILL_WRITE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  beat_ctr;
    logic [1:0]  beat_nxt;
    logic [27:0] line_pa;
    logic        beat_ack;
    logic        last_beat;

    // Bits [3:0] of the address and the cache size do not affect the fill.
    logic unused_ok;
    assign unused_ok = ^{i_fill_pa[3:0], 1'(CACHE_SIZE & 1)};

    assign beat_ack  = (state == S_FILL_READ) && i_wb_ack && o_wb_stb;
    assign last_beat = beat_ack && (beat_ctr == 2'd3);
    assign beat_nxt  = beat_ctr + 2'd1;

    assign o_wb_wen          = 1'b0;
    assign o_cache_tag_dirty = 1'b0;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (i_fill_req) state_nxt = S_FILL_READ;
            S_FILL_READ:  if (last_beat)  state_nxt = S_FILL_WRITE;
            S_FILL_WRITE: state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Write-side strobes decode directly from state
    always_comb begin
        o_fill_busy       = (state != S_IDLE);
        o_fill_done       = (state == S_FILL_WRITE);
        o_cache_tag_wr_en = (state == S_FILL_WRITE);
        o_cache_line_ben  = (state == S_FILL_WRITE) ? 16'hFFFF : 16'h0000;
    end

    // Wishbone master registers, beat counter and line/tag capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_sel     <= 4'b0000;
            o_wb_adr     <= 32'd0;
            o_wb_cti     <= CTI_CLASSIC;
            beat_ctr     <= 2'd0;
            line_pa      <= 28'd0;
            o_cache_line <= '0;
            o_cache_tag  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_fill_req) begin
                        line_pa     <= i_fill_pa[31:4];
                        o_cache_tag <= i_fill_tag;
                        beat_ctr    <= 2'd0;
                        o_wb_cyc    <= 1'b1;
                        o_wb_stb    <= 1'b1;
                        o_wb_sel    <= 4'b1111;
                        o_wb_adr    <= {i_fill_pa[31:4], 4'd0};
                        o_wb_cti    <= CTI_BURST;
                    end
                end
                S_FILL_READ: begin
                    if (beat_ack) begin
                        // Beat k lands in word k of the line
                        o_cache_line[{beat_ctr, 5'd0} +: 32] <= i_wb_dat;
                        beat_ctr <= beat_nxt;
                        if (beat_ctr == 2'd3) begin
                            o_wb_cyc <= 1'b0;
                            o_wb_stb <= 1'b0;
                            o_wb_sel <= 4'b0000;
                            o_wb_adr <= 32'd0;
                            o_wb_cti <= CTI_CLASSIC;
                        end else begin
                            // Line-aligned start, so the word index never carries into the line address
                            o_wb_adr <= {line_pa, beat_nxt, 2'b00};
                            o_wb_cti <= (beat_nxt == 2'd3) ? CTI_EOB : CTI_BURST;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_cache_line_fill.sv
// tb/tb_zap_cache_line_fill.sv - directed self-checking bench for zap_cache_line_fill

module tb_zap_cache_line_fill;
    import zap_cache_line_fill_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     fill_req;
    logic [31:0]              fill_pa;
    logic [CACHE_TAG_WDT-1:0] fill_tag;
    logic                     fill_busy;
    logic                     fill_done;
    logic [LINE_BITS-1:0]     cache_line;
    logic [15:0]              cache_line_ben;
    logic                     cache_tag_wr_en;
    logic [CACHE_TAG_WDT-1:0] cache_tag;
    logic                     cache_tag_dirty;
    logic                     wb_cyc;
    logic                     wb_stb;
    logic [31:0]              wb_adr;
    logic                     wb_wen;
    logic [3:0]               wb_sel;
    logic [2:0]               wb_cti;
    logic                     wb_ack;
    logic [31:0]              wb_dat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    zap_cache_line_fill #(.CACHE_SIZE(1024)) u_dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_fill_req        (fill_req),
        .i_fill_pa         (fill_pa),
        .i_fill_tag        (fill_tag),
        .o_fill_busy       (fill_busy),
        .o_fill_done       (fill_done),
        .o_cache_line      (cache_line),
        .o_cache_line_ben  (cache_line_ben),
        .o_cache_tag_wr_en (cache_tag_wr_en),
        .o_cache_tag       (cache_tag),
        .o_cache_tag_dirty (cache_tag_dirty),
        .o_wb_cyc          (wb_cyc),
        .o_wb_stb          (wb_stb),
        .o_wb_adr          (wb_adr),
        .o_wb_wen          (wb_wen),
        .o_wb_sel          (wb_sel),
        .o_wb_cti          (wb_cti),
        .i_wb_ack          (wb_ack),
        .i_wb_dat          (wb_dat)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one fill from request to the first IDLE cycle after the write.
    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_fill(input logic [31:0] pa, input logic [27:0] tag,
                            input logic [127:0] line, input logic [31:0] exp_base,
                            input int waits, input bit hold, input bit repulse);
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        fill_req = 1'b1;
        fill_pa  = pa;
        fill_tag = tag;
        @(negedge clk);
        if (!hold) fill_req = 1'b0;
        check("start_cyc",  wb_cyc,    1'b1);
        check("start_stb",  wb_stb,    1'b1);
        check("start_sel",  wb_sel,    4'b1111);
        check("start_adr",  wb_adr,    exp_base);
        check("start_busy", fill_busy, 1'b1);
        for (int b = 0; b < 4; b++) begin
            exp_adr = exp_base + 32'(4 * b);
            exp_cti = (b == 3) ? 3'b111 : 3'b010;
            for (int w = 0; w < waits; w++) begin
                if (repulse && b == 1 && w == 0) fill_req = 1'b1;
                else if (!hold)                  fill_req = 1'b0;
                check("wait_adr",  wb_adr,    exp_adr);
                check("wait_cti",  wb_cti,    exp_cti);
                check("wait_cyc",  wb_cyc,    1'b1);
                check("wait_done", fill_done, 1'b0);
                @(negedge clk);
            end
            if (!hold) fill_req = 1'b0;
            check("beat_adr",  wb_adr,    exp_adr);
            check("beat_cti",  wb_cti,    exp_cti);
            check("beat_stb",  wb_stb,    1'b1);
            check("beat_done", fill_done, 1'b0);
            wb_ack = 1'b1;
            wb_dat = line[32*b +: 32];
            @(negedge clk);
            wb_ack = 1'b0;
            wb_dat = 32'h0;
        end
        check("wr_done",  fill_done,       1'b1);
        check("wr_tagwe", cache_tag_wr_en, 1'b1);
        check("wr_ben",   cache_line_ben,  16'hFFFF);
        check("wr_cyc",   wb_cyc,          1'b0);
        check("wr_stb",   wb_stb,          1'b0);
        check("wr_sel",   wb_sel,          4'b0000);
        check("wr_adr",   wb_adr,          32'h0);
        check("wr_cti",   wb_cti,          3'b000);
        check("wr_busy",  fill_busy,       1'b1);
        check("wr_line",  cache_line,      line);
        check("wr_tag",   cache_tag,       tag);
        check("wr_dirty", cache_tag_dirty, 1'b0);
        @(negedge clk);
        check("post_done",  fill_done,       1'b0);
        check("post_tagwe", cache_tag_wr_en, 1'b0);
        check("post_ben",   cache_line_ben,  16'h0000);
        check("post_busy",  fill_busy,       1'b0);
        check("post_cyc",   wb_cyc,          1'b0);
        check("post_line",  cache_line,      line);
        check("post_tag",   cache_tag,       tag);
    endtask

    initial begin
        rst      = 1'b1;
        fill_req = 1'b0;
        fill_pa  = 32'h0;
        fill_tag = '0;
        wb_ack   = 1'b0;
        wb_dat   = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values
        check("rst_cyc",   wb_cyc,          1'b0);
        check("rst_stb",   wb_stb,          1'b0);
        check("rst_wen",   wb_wen,          1'b0);
        check("rst_sel",   wb_sel,          4'b0000);
        check("rst_adr",   wb_adr,          32'h0);
        check("rst_cti",   wb_cti,          3'b000);
        check("rst_busy",  fill_busy,       1'b0);
        check("rst_done",  fill_done,       1'b0);
        check("rst_tagwe", cache_tag_wr_en, 1'b0);
        check("rst_ben",   cache_line_ben,  16'h0000);
        check("rst_line",  cache_line,      128'h0);
        check("rst_tag",   cache_tag,       28'h0);
        check("rst_dirty", cache_tag_dirty, 1'b0);

        // Zero-wait fill
        run_fill(32'h0000_1230, 28'h000_0123,
                 128'h44444444_33333333_22222222_11111111, 32'h0000_1230, 0, 1'b0, 1'b0);

        // Spurious acks in IDLE
        wb_ack = 1'b1;
        wb_dat = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_cyc",  wb_cyc,     1'b0);
            check("spur_busy", fill_busy,  1'b0);
            check("spur_line", cache_line, 128'h44444444_33333333_22222222_11111111);
        end
        wb_ack = 1'b0;
        wb_dat = 32'h0;

        // Wait states with a re-pulsed request during the burst
        run_fill(32'h0000_2000, 28'h000_0200,
                 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 32'h0000_2000, 3, 1'b0, 1'b1);
        @(negedge clk);
        check("noextra_cyc",  wb_cyc,    1'b0);
        check("noextra_busy", fill_busy, 1'b0);

        // Unaligned address
        run_fill(32'h8000_004C, 28'h800_0004,
                 128'h0BADF00D_CAFEBABE_12345678_87654321, 32'h8000_0040, 0, 1'b0, 1'b0);

        // Reset after the second ack
        fill_req = 1'b1;
        fill_pa  = 32'h0000_3000;
        fill_tag = 28'h000_0300;
        @(negedge clk);
        fill_req = 1'b0;
        wb_ack   = 1'b1;
        wb_dat   = 32'h5555_0000;
        @(negedge clk);
        wb_dat   = 32'h5555_0001;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat   = 32'h0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        check("abort_cyc",   wb_cyc,          1'b0);
        check("abort_stb",   wb_stb,          1'b0);
        check("abort_busy",  fill_busy,       1'b0);
        check("abort_tagwe", cache_tag_wr_en, 1'b0);
        check("abort_line",  cache_line,      128'h0);
        check("abort_tag",   cache_tag,       28'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_idle_tagwe", cache_tag_wr_en, 1'b0);
            check("abort_idle_cyc",   wb_cyc,          1'b0);
        end
        run_fill(32'h0000_3000, 28'h000_0300,
                 128'h66660003_66660002_66660001_66660000, 32'h0000_3000, 0, 1'b0, 1'b0);

        // Back-to-back with the request held high
        run_fill(32'h0000_4000, 28'h000_0400,
                 128'h77770003_77770002_77770001_77770000, 32'h0000_4000, 0, 1'b1, 1'b0);
        run_fill(32'h0000_4000, 28'h000_0400,
                 128'h88880003_88880002_88880001_88880000, 32'h0000_4000, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_end_cyc",  wb_cyc,    1'b0);
        check("b2b_end_busy", fill_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zap_cache_line_fill.md
# zap_cache_line_fill

Cache line refill engine that sits directly upstream of the cache tag/data RAM. On a miss, the cache controller hands it a line-aligned physical address and a precomputed tag. The block performs a 4-beat incrementing Wishbone burst read and assembles the 128-bit line. It then issues a single-cycle full-line write, with tag write, into the tag/data RAM. It owns its own Wishbone master port, which is merged with the RAM's clean port by the existing memory arbiter.

## Interface
Parameters:
- CACHE_SIZE, 1024: cache size in bytes. Carried for consistency with the tag RAM; it does not affect fill datapath widths.

Ports:
- i_clk  in  1  clock. The single clock; all logic is on its rising edge.
- i_reset  in  1  reset. Synchronous, active-high.
- i_fill_req  in  1  level request. Sampled only in IDLE.
- i_fill_pa  in  32  fill physical address. Bits [3:0] are ignored; the line is aligned.
- i_fill_tag  in  `CACHE_TAG_WDT  tag to install. Its PA field must match i_fill_pa[31:4].
- o_fill_busy  out  1  high whenever the state is not IDLE.
- o_fill_done  out  1  one-cycle pulse, coincident with the RAM write.
- o_cache_line  out  128  assembled line. Word k occupies bits [32k+31:32k].
- o_cache_line_ben  out  16  16'hFFFF during the write cycle, else 0.
- o_cache_tag_wr_en  out  1  one-cycle tag write strobe.
- o_cache_tag  out  `CACHE_TAG_WDT  latched i_fill_tag.
- o_cache_tag_dirty  out  1  constant 0; freshly filled lines are clean.
- o_wb_cyc, o_wb_stb  out  1  registered Wishbone strobes.
- o_wb_adr  out  32  registered word address.
- o_wb_wen  out  1  constant 0.
- o_wb_sel  out  4  4'b1111 while cyc is high, else 0.
- o_wb_cti  out  3  CTI_BURST for beats 0-2, CTI_EOB for beat 3, CTI_CLASSIC when idle.
- i_wb_ack  in  1  beat acknowledge.
- i_wb_dat  in  32  read data, valid with ack.

## Operation
- States: IDLE, FILL_READ, FILL_WRITE. Internal state is a 2-bit beat counter beat_ctr and a 128-bit line buffer.
- IDLE, i_fill_req=1:
  - Latch pa={i_fill_pa[31:4],4'd0} and i_fill_tag.
  - Clear beat_ctr.
  - Next cycle: cyc=stb=1, adr=pa, cti=CTI_BURST.
  - Go to FILL_READ.
- FILL_READ, each cycle with i_wb_ack && o_wb_stb:
  - Store i_wb_dat into line word beat_ctr, then increment beat_ctr.
  - Next adr = pa + 4*(beat_ctr+1).
  - cti is CTI_EOB when the next beat is 3.
- Fourth ack (beat_ctr==3): next cycle cyc=stb=0, sel=0, adr=0, cti=CTI_CLASSIC. Go to FILL_WRITE.
- FILL_READ without ack: all Wishbone outputs hold (wait states of any length).
- FILL_WRITE, exactly one cycle:
  - o_cache_tag_wr_en=1, o_cache_line_ben=16'hFFFF, o_fill_done=1.
  - Go to IDLE.
- Word order: beat 0 -> bits [31:0] … beat 3 -> bits [127:96]. This is the same packing the clean path unpacks.
- Addresses never wrap. The burst always starts at word 0 of the line.
- Ack while stb=0, or in IDLE/FILL_WRITE: ignored, no state change.
- i_fill_req while busy: ignored. A request still high on return to IDLE starts a new fill; deasserting it after o_fill_done is the controller's job.
- Reset in any state: the next cycle is IDLE with all outputs at reset values. A partially filled line is discarded and no tag write occurs.

## Timing
- Reset values:
  - cyc, stb, wen = 0; sel = 0; adr = 0; cti = CTI_CLASSIC.
  - busy, done, tag_wr_en = 0; ben = 0.
  - o_cache_line = 0; o_cache_tag = 0; dirty = 0.
- All Wishbone outputs are flop outputs. The write-side strobes (tag_wr_en, ben, done) decode from state; the line and tag are flops.
- Request sampled at cycle N: cyc/stb high at N+1.
- Zero-wait acks at N+1..N+4: write/done at N+5, busy low at N+6, next request acceptable at N+6.
- Latency with W total wait cycles: 5+W cycles from request to done.
- o_cache_line and o_cache_tag are stable throughout FILL_WRITE and hold afterwards.

## Structure
- CTI_CLASSIC, CTI_BURST and CTI_EOB come from zap_localparams.vh.
- `CACHE_TAG_WDT and `CACHE_TAG__PA come from zap_defines.vh. The state encoding is local.
- Single module; no sub-module is warranted.

## Test plan
- Zero-wait fill:
  - Stimulus: pa=0x0000_1230; acks on consecutive cycles with data 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required response: adr sequence 0x1230, 0x1234, 0x1238, 0x123C; cti 010,010,010,111; line = 0x44444444_33333333_22222222_11111111; done 5 cycles after request; ben=FFFF for exactly 1 cycle.
- Wait states:
  - Stimulus: 3 idle cycles before each ack.
  - Required response: adr/dat/cti held steady during waits; done at request+17.
- Unaligned pa:
  - Stimulus: pa=0x8000_004C.
  - Required response: first adr 0x8000_0040; tag written unchanged.
- Reset mid-burst:
  - Stimulus: assert i_reset after the 2nd ack.
  - Required response: next cycle cyc=stb=0, busy=0; tag_wr_en never asserts; a subsequent fill completes correctly.
- Spurious acks and early requests:
  - Stimulus: ack in IDLE; re-pulse i_fill_req during FILL_READ.
  - Required response: no state change, no extra burst.
- Back-to-back:
  - Stimulus: i_fill_req held high.
  - Required response: second burst cyc rises at N+7; a 1-cycle cyc=0 gap plus 1 write cycle precedes it.
